// File: rtl/rv_mem_pkg.sv
// Shared definitions for the MEM-stage data memory access path.
// Holds the funct3 load/store encodings, the access FSM state type and
// a legality helper so the access unit and any future writeback logic
// agree on which accesses are allowed.
package rv_mem_pkg;

  // funct3 encodings of the load instructions
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  // funct3 encodings of the store instructions
  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_f3_e;

  // Access FSM: wait for an access, hold the request, release the pipeline
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns 1 when the access size is a known encoding and the byte
  // address is naturally aligned for that size.
  function automatic logic access_legal(input logic       is_load,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    if (is_load) begin
      case (funct3)
        LB, LBU: ok = 1'b1;
        LH, LHU: ok = ~offset[0];
        LW:      ok = (offset == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        SB:      ok = 1'b1;
        SH:      ok = ~offset[0];
        SW:      ok = (offset == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/datamem_access_unit_if.sv
// Handshaked data memory bus.
// Ports (signals):
//   mem_req   request valid toward memory
//   mem_we    1 = write, 0 = read
//   mem_addr  word-aligned byte address
//   mem_be    byte enables, one per byte lane
//   mem_wdata lane-aligned store data
//   mem_ready one-cycle accept/complete pulse from memory
//   mem_rdata read word, valid with mem_ready
// master = the access unit, slave = the memory.
interface datamem_access_unit_if #(
  parameter int DATA_W = 32
);

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/load_extend.sv
// Combinational load data formatter.
// Picks the addressed byte or half-word out of a read word and sign- or
// zero-extends it according to the load funct3; LW passes the word.
// Ports:
//   rdata  in  32  raw word returned by memory
//   offset in  2   byte offset of the original address
//   funct3 in  3   load funct3
//   ext    out 32  extended load result
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection first, then extension; halves only ever sit on
  // offset 0 or 2, so offset[1] alone chooses the half.
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    ext      = rdata;
    case (funct3)
      LB:      ext = {{24{byte_sel[7]}}, byte_sel};
      LBU:     ext = {24'h000000, byte_sel};
      LH:      ext = {{16{half_sel[15]}}, half_sel};
      LHU:     ext = {16'h0000, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/datamem_access_unit.sv
// MEM-stage bridge from decoded load/store controls to a handshaked,
// variable-latency data memory.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   MemRead/MemWrite  load / store request of the instruction in MEM
//   Funct3            access size and signedness
//   Addr, WrData      byte address and store data (rs2)
//   RdData            extended load result, valid in DONE
//   stall             freeze the pipeline this cycle
//   fault             one-cycle pulse: misaligned, illegal or timed out
//   mem               master side of the memory bus interface
module datamem_access_unit
  import rv_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     Addr,
  input  logic [DATA_W-1:0]     WrData,
  output logic [DATA_W-1:0]     RdData,
  output logic                  stall,
  output logic                  fault,
  datamem_access_unit_if.master mem
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e               state_q;
  state_e               state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           off_q;
  logic [2:0]           f3_q;
  logic                 we_q;
  logic                 req_q;
  logic [DATA_W-1:0]    addr_q;
  logic [3:0]           be_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    rd_q;
  logic                 fault_q;

  logic                 access;
  logic                 legal;
  logic                 start;
  logic                 illegal;
  logic                 timed_out;
  logic [3:0]           be_d;
  logic [DATA_W-1:0]    wdata_d;
  logic [DATA_W-1:0]    ext_data;

  // A well-formed access is exactly one of load/store; asking for both
  // at once is treated as an illegal access rather than picking one.
  assign access    = MemRead ^ MemWrite;
  assign legal     = access_legal(MemRead, Funct3, Addr[1:0]);
  assign start     = access && legal;
  assign illegal   = (access && !legal) || (MemRead && MemWrite);
  assign timed_out = (cnt_q == CNT_LAST);

  assign RdData        = rd_q;
  assign fault         = fault_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  // Store lane steering: the data is replicated across every lane and
  // the byte enables pick the lanes memory actually writes. Loads always
  // fetch the whole word and extract the lane on the way back.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    if (MemWrite) begin
      wdata_d = WrData;
      case (Funct3)
        SB: begin
          be_d    = 4'b0001 << Addr[1:0];
          wdata_d = {4{WrData[7:0]}};
        end
        SH: begin
          be_d    = 4'b0011 << {Addr[1], 1'b0};
          wdata_d = {2{WrData[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = WrData;
        end
      endcase
    end
  end

  // Load result formatting uses the offset and funct3 captured when the
  // request was issued, since the pipeline inputs may not stay valid.
  load_extend u_load_extend (
    .rdata  (mem.mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .ext    (ext_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the combinational stall. The first cycle of a legal
  // access stalls straight from the inputs so the instruction is held
  // before the request register has even been loaded. DONE is a single
  // unstalled cycle that lets the instruction leave MEM, and it never
  // starts a new access because the same instruction is still present.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) begin
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem.mem_ready || timed_out) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request, result and fault registers. fault defaults low every cycle
  // so any set below is a single-cycle pulse. A timeout returns zero
  // data so a stale result never reaches writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start) begin
            req_q   <= 1'b1;
            we_q    <= MemWrite;
            addr_q  <= {Addr[DATA_W-1:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= Addr[1:0];
            f3_q    <= Funct3;
          end else if (illegal) begin
            fault_q <= 1'b1;
            rd_q    <= '0;
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            req_q <= 1'b0;
            rd_q  <= we_q ? '0 : ext_data;
          end else if (timed_out) begin
            req_q   <= 1'b0;
            rd_q    <= '0;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_access_unit.sv
// Self-checking bench for datamem_access_unit: a table of directed
// load/store vectors with hand-computed results, plus hand-written
// sequences for timeout, reset in mid-request and late mem_ready.
module tb_datamem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        stall;
  logic        fault;

  int tests_run;
  int tests_failed;

  datamem_access_unit_if #(.DATA_W(32)) mem_bus ();

  datamem_access_unit #(
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Funct3   (Funct3),
    .Addr     (Addr),
    .WrData   (WrData),
    .RdData   (RdData),
    .stall    (stall),
    .fault    (fault),
    .mem      (mem_bus.master)
  );

  typedef struct {
    string       name;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    int          ready_delay;
    logic        exp_fault;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        check_rd;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NUM_VECS = 18;
  vec_t vecs [NUM_VECS];

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream wedges the bench
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    MemRead  = rd;
    MemWrite = wr;
    Funct3   = f3;
    Addr     = addr;
    WrData   = wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One full access: issue in IDLE, answer after ready_delay REQ cycles,
  // check DONE, then drop the controls.
  task automatic runVector(input vec_t v);
    int  req_cycles;
    int  stall_cycles;
    bit  done;
    bit  req_dropped;
    @(posedge clk); #1;
    applyStimulus(v.mem_read, v.mem_write, v.funct3, v.addr, v.wr_data);
    #1;
    checkOutput($sformatf("%s.stall_first", v.name), {31'b0, stall}, {31'b0, !v.exp_fault});
    if (v.exp_fault) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      checkOutput($sformatf("%s.fault", v.name),   {31'b0, fault},           32'd1);
      checkOutput($sformatf("%s.mem_req", v.name), {31'b0, mem_bus.mem_req}, 32'd0);
      checkOutput($sformatf("%s.stall", v.name),   {31'b0, stall},           32'd0);
      checkOutput($sformatf("%s.rddata", v.name),  RdData,                   32'h0);
      @(posedge clk); #1;
      checkOutput($sformatf("%s.fault_end", v.name), {31'b0, fault},         32'd0);
    end else begin
      stall_cycles = 1;
      req_cycles   = 0;
      done         = 1'b0;
      req_dropped  = 1'b0;
      @(posedge clk); #1;
      checkOutput($sformatf("%s.mem_we", v.name),   {31'b0, mem_bus.mem_we}, {31'b0, v.exp_we});
      checkOutput($sformatf("%s.mem_addr", v.name), mem_bus.mem_addr,        v.exp_addr);
      checkOutput($sformatf("%s.mem_be", v.name),   {28'b0, mem_bus.mem_be}, {28'b0, v.exp_be});
      if (v.exp_we) begin
        checkOutput($sformatf("%s.mem_wdata", v.name), mem_bus.mem_wdata, v.exp_wdata);
      end
      while (!done && req_cycles < 32) begin
        req_cycles++;
        if (stall) stall_cycles++;
        if (mem_bus.mem_req !== 1'b1) req_dropped = 1'b1;
        if (req_cycles == v.ready_delay) begin
          mem_bus.mem_ready = 1'b1;
          mem_bus.mem_rdata = v.rd_data;
        end
        @(posedge clk); #1;
        if (mem_bus.mem_ready) begin
          mem_bus.mem_ready = 1'b0;
          mem_bus.mem_rdata = 32'h0;
          done = 1'b1;
        end
      end
      checkOutput($sformatf("%s.ready_reached", v.name), {31'b0, done},        32'd1);
      checkOutput($sformatf("%s.req_held", v.name),      {31'b0, req_dropped}, 32'd0);
      checkOutput($sformatf("%s.stall_cycles", v.name),  stall_cycles,         v.ready_delay + 1);
      checkOutput($sformatf("%s.done_stall", v.name),    {31'b0, stall},       32'd0);
      checkOutput($sformatf("%s.done_req", v.name),      {31'b0, mem_bus.mem_req}, 32'd0);
      checkOutput($sformatf("%s.done_fault", v.name),    {31'b0, fault},       32'd0);
      if (v.check_rd) begin
        checkOutput($sformatf("%s.rddata", v.name), RdData, v.exp_rd);
      end
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      checkOutput($sformatf("%s.no_restart", v.name), {31'b0, mem_bus.mem_req}, 32'd0);
    end
  endtask

  initial begin
    int   req_cycles;
    bit   stall_low;
    vec_t v;

    tests_run    = 0;
    tests_failed = 0;

    //            name         rd    wr    f3      addr          wr_data       rd_data       dly flt   we    exp_addr      be       exp_wdata     chk   exp_rd
    vecs[0]  = '{"lw_100",    1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 1'b0, 32'h00000100, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[1]  = '{"lb_103",    1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80AABBCC, 1, 1'b0, 1'b0, 32'h00000100, 4'b1111, 32'h0,        1'b1, 32'hFFFFFF80};
    vecs[2]  = '{"lbu_103",   1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0,        32'h80AABBCC, 2, 1'b0, 1'b0, 32'h00000100, 4'b1111, 32'h0,        1'b1, 32'h00000080};
    vecs[3]  = '{"lhu_102",   1'b1, 1'b0, 3'b101, 32'h00000102, 32'h0,        32'h80AABBCC, 1, 1'b0, 1'b0, 32'h00000100, 4'b1111, 32'h0,        1'b1, 32'h000080AA};
    vecs[4]  = '{"lh_102",    1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0,        32'h80AABBCC, 4, 1'b0, 1'b0, 32'h00000100, 4'b1111, 32'h0,        1'b1, 32'hFFFF80AA};
    vecs[5]  = '{"lb_100",    1'b1, 1'b0, 3'b000, 32'h00000100, 32'h0,        32'h80AABBCC, 1, 1'b0, 1'b0, 32'h00000100, 4'b1111, 32'h0,        1'b1, 32'hFFFFFFCC};
    vecs[6]  = '{"lbu_101",   1'b1, 1'b0, 3'b100, 32'h00000101, 32'h0,        32'h80AABBCC, 1, 1'b0, 1'b0, 32'h00000100, 4'b1111, 32'h0,        1'b1, 32'h000000BB};
    vecs[7]  = '{"lh_100",    1'b1, 1'b0, 3'b001, 32'h00000100, 32'h0,        32'h12348765, 2, 1'b0, 1'b0, 32'h00000100, 4'b1111, 32'h0,        1'b1, 32'hFFFF8765};
    vecs[8]  = '{"sb_201",    1'b0, 1'b1, 3'b000, 32'h00000201, 32'h12345678, 32'h0,        2, 1'b0, 1'b1, 32'h00000200, 4'b0010, 32'h78787878, 1'b0, 32'h0};
    vecs[9]  = '{"sh_202",    1'b0, 1'b1, 3'b001, 32'h00000202, 32'h12345678, 32'h0,        1, 1'b0, 1'b1, 32'h00000200, 4'b1100, 32'h56785678, 1'b0, 32'h0};
    vecs[10] = '{"sw_204",    1'b0, 1'b1, 3'b010, 32'h00000204, 32'hCAFEF00D, 32'h0,        1, 1'b0, 1'b1, 32'h00000204, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[11] = '{"sb_203",    1'b0, 1'b1, 3'b000, 32'h00000203, 32'h000000A5, 32'h0,        3, 1'b0, 1'b1, 32'h00000200, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[12] = '{"lw_101",    1'b1, 1'b0, 3'b010, 32'h00000101, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[13] = '{"sh_203",    1'b0, 1'b1, 3'b001, 32'h00000203, 32'h12345678, 32'h0,        0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{"lh_101",    1'b1, 1'b0, 3'b001, 32'h00000101, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[15] = '{"ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h00000100, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[16] = '{"st_f3_100", 1'b0, 1'b1, 3'b100, 32'h00000100, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[17] = '{"rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h00000100, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};

    // Reset state
    reset             = 1'b1;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
    checkOutput("reset.mem_be",  {28'b0, mem_bus.mem_be},  32'd0);
    checkOutput("reset.rddata",  RdData,                   32'h0);
    checkOutput("reset.fault",   {31'b0, fault},           32'd0);
    checkOutput("reset.stall",   {31'b0, stall},           32'd0);
    reset = 1'b0;

    // Table-driven accesses
    for (int i = 0; i < NUM_VECS; i++) begin
      runVector(vecs[i]);
    end

    // Timeout: load a known result first so the zeroing is visible
    runVector(vecs[0]);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000300, 32'h0);
    @(posedge clk); #1;
    req_cycles = 0;
    stall_low  = 1'b0;
    while (mem_bus.mem_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      if (stall !== 1'b1) stall_low = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("timeout.req_cycles", req_cycles,              32'd16);
    checkOutput("timeout.stall_held", {31'b0, stall_low},      32'd0);
    checkOutput("timeout.fault",      {31'b0, fault},          32'd1);
    checkOutput("timeout.rddata",     RdData,                  32'h0);
    checkOutput("timeout.done_stall", {31'b0, stall},          32'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("timeout.fault_end",  {31'b0, fault},          32'd0);
    checkOutput("timeout.idle_req",   {31'b0, mem_bus.mem_req}, 32'd0);

    // Reset during the second REQ cycle, then a late mem_ready in IDLE
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000400, 32'h0);
    @(posedge clk); #1;
    checkOutput("rst_mid.req_cycle1", {31'b0, mem_bus.mem_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_mid.mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
    checkOutput("rst_mid.stall",   {31'b0, stall},           32'd0);
    checkOutput("rst_mid.fault",   {31'b0, fault},           32'd0);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    checkOutput("late_ready.stall",   {31'b0, stall},           32'd0);
    checkOutput("late_ready.fault",   {31'b0, fault},           32'd0);
    checkOutput("late_ready.mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
    checkOutput("late_ready.rddata",  RdData,                   32'h0);

    // A following word load completes normally
    v = '{"lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h00000404, 32'h0, 32'h11223344, 1, 1'b0, 1'b0,
          32'h00000404, 4'b1111, 32'h0, 1'b1, 32'h11223344};
    runVector(v);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
